// File: rtl/hex_display_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : hex_display_arbiter_if
//  Description : Bundle of request/data inputs and display-bus outputs for
//                the hex display arbiter. The master side owns the requests
//                and source values; the slave side is the arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface hex_display_arbiter_if #(
    parameter int N_SRC = 4
);
    logic [N_SRC-1:0]    req;
    logic [32*N_SRC-1:0] src_data;
    logic                freeze;
    logic [N_SRC-1:0]    grant;
    logic [2:0]          grant_idx;
    logic [31:0]         hex;
    logic                hex_valid;
    logic                slice_done;

    modport master (
        output req, src_data, freeze,
        input  grant, grant_idx, hex, hex_valid, slice_done
    );

    modport slave (
        input  req, src_data, freeze,
        output grant, grant_idx, hex, hex_valid, slice_done
    );
endinterface
`default_nettype wire

// File: rtl/hex_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : hex_display_arbiter
//  Description : Round-robin time-slicing arbiter sharing one 32-bit hex
//                display value among N_SRC requesters. Each owner keeps the
//                display for DWELL cycles, releases early when its request
//                drops, and freeze suspends timed rotation. All outputs are
//                registered.
//  Revision    : 1.0  initial release
// ============================================================================
module hex_display_arbiter #(
    parameter int N_SRC = 4,
    parameter int DWELL = 50000000,
    parameter int CW    = $clog2(DWELL)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    hex_display_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam logic [CW-1:0] c_count_max = CW'(DWELL - 1);
    localparam logic [CW-1:0] c_count_one = CW'(1);
    localparam logic [2:0]    c_last_init = 3'(N_SRC - 1);

    state_t             r_state;
    logic [2:0]         r_last;
    logic [CW-1:0]      r_count;
    logic [N_SRC-1:0]   r_grant;
    logic [2:0]         r_grant_idx;
    logic [31:0]        r_hex;
    logic               r_hex_valid;
    logic               r_slice_done;

    logic               w_any_req;
    logic               w_owner_req;
    int                 w_best_rank;
    logic [2:0]         w_pick;
    logic [31:0]        w_pick_data;
    logic [31:0]        w_owner_data;

    function automatic logic [N_SRC-1:0] f_onehot(input logic [2:0] idx);
        f_onehot = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (3'(i) == idx) begin
                f_onehot[i] = 1'b1;
            end
        end
    endfunction

    // Round-robin winner search. Each requester gets a rank equal to its
    // distance past r_last, so the source at r_last itself ranks last. While
    // granted, r_last is the owner: the plain search therefore prefers any
    // other requester and falls back to the owner only when it is alone, and
    // a non-requesting owner can never be selected.
    always_comb begin
        w_any_req    = |bus.req;
        w_owner_req  = |(bus.req & r_grant);
        w_best_rank  = N_SRC;
        w_pick       = '0;
        w_pick_data  = '0;
        w_owner_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (bus.req[i] &&
                (((i + 2 * N_SRC - int'(r_last) - 1) % N_SRC) < w_best_rank)) begin
                w_best_rank = (i + 2 * N_SRC - int'(r_last) - 1) % N_SRC;
                w_pick      = 3'(i);
            end
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (3'(i) == w_pick) begin
                w_pick_data = bus.src_data[32*i +: 32];
            end
            if (3'(i) == r_grant_idx) begin
                w_owner_data = bus.src_data[32*i +: 32];
            end
        end
    end

    // Arbitration FSM: ownership, dwell timing and the registered display bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last       <= c_last_init;
            r_count      <= '0;
            r_grant      <= '0;
            r_grant_idx  <= '0;
            r_hex        <= '0;
            r_hex_valid  <= 1'b0;
            r_slice_done <= 1'b0;
        end else begin
            r_slice_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state     <= S_GRANT;
                        r_grant     <= f_onehot(w_pick);
                        r_grant_idx <= w_pick;
                        r_hex       <= w_pick_data;
                        r_hex_valid <= 1'b1;
                        r_count     <= '0;
                        r_last      <= w_pick;
                    end
                end
                S_GRANT: begin
                    if (!w_owner_req) begin
                        // Early release: hand over at once, never back to the owner.
                        r_count <= '0;
                        if (w_any_req) begin
                            r_grant     <= f_onehot(w_pick);
                            r_grant_idx <= w_pick;
                            r_hex       <= w_pick_data;
                            r_last      <= w_pick;
                        end else begin
                            r_state     <= S_IDLE;
                            r_grant     <= '0;
                            r_grant_idx <= '0;
                            r_hex       <= '0;
                            r_hex_valid <= 1'b0;
                        end
                    end else if ((r_count == c_count_max) && !bus.freeze) begin
                        // Timed expiry: rotate, or restart the slice if alone.
                        r_slice_done <= 1'b1;
                        r_count      <= '0;
                        r_grant      <= f_onehot(w_pick);
                        r_grant_idx  <= w_pick;
                        r_hex        <= w_pick_data;
                        r_last       <= w_pick;
                    end else begin
                        if (!bus.freeze) begin
                            r_count <= r_count + c_count_one;
                        end
                        r_hex <= w_owner_data;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.grant      = r_grant;
    assign bus.grant_idx  = r_grant_idx;
    assign bus.hex        = r_hex;
    assign bus.hex_valid  = r_hex_valid;
    assign bus.slice_done = r_slice_done;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_display_arbiter
//  Description : Self-checking bench for hex_display_arbiter with a
//                behavioural ownership model and directed/random scenarios.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hex_display_arbiter;

    localparam int N     = 4;
    localparam int DWELL = 4;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    hex_display_arbiter_if #(.N_SRC(N)) bus ();

    hex_display_arbiter #(.N_SRC(N), .DWELL(DWELL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: owner index (-1 = idle), last winner, slice age.
    int          m_owner;
    int          m_last;
    int          m_age;
    logic [31:0] m_hex;
    logic        m_sd;

    function automatic int first_req(input logic [N-1:0] r, input int last, input int skip);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (idx != skip && r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    function automatic logic [N+37:0] m_vec();
        return {m_grant(), (m_owner >= 0) ? 3'(m_owner) : 3'd0, m_hex,
                (m_owner >= 0), m_sd};
    endfunction

    function automatic logic [N+37:0] dut_vec();
        return {bus.grant, bus.grant_idx, bus.hex, bus.hex_valid, bus.slice_done};
    endfunction

    task automatic model_edge();
        logic [N-1:0]    r;
        logic [32*N-1:0] d;
        int              w;
        r = bus.req;
        d = bus.src_data;
        m_sd = 1'b0;
        if (reset) begin
            m_owner = -1; m_last = N - 1; m_age = 0; m_hex = '0;
        end else if (m_owner < 0) begin
            if (r != '0) begin
                w = first_req(r, m_last, -1);
                m_owner = w; m_last = w; m_age = 0; m_hex = d[32*w +: 32];
            end
        end else if (!r[m_owner]) begin
            m_age = 0;
            if (r != '0) begin
                w = first_req(r, m_last, m_owner);
                m_owner = w; m_last = w; m_hex = d[32*w +: 32];
            end else begin
                m_owner = -1; m_hex = '0;
            end
        end else if (m_age == DWELL - 1 && !bus.freeze) begin
            m_sd = 1'b1;
            w = first_req(r, m_last, m_owner);
            if (w < 0) w = m_owner;
            m_owner = w; m_last = w; m_age = 0; m_hex = d[32*w +: 32];
        end else begin
            if (!bus.freeze) m_age = m_age + 1;
            m_hex = d[32*m_owner +: 32];
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req = '0;
        bus.freeze = 1'b0;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.req = '1;
        bus.src_data = {$urandom, $urandom, $urandom, $urandom};
        reset = 1'b1;
        cycle();
        checks++;
        if (dut_vec() !== '0) begin
            failures++;
            $display("FAIL reset_outputs actual=%h expected=0", dut_vec());
        end
        reset = 1'b0;
        bus.req = '0;
        cycle();
    endtask

    task automatic test_rotation();
        int order[$];
        do_reset();
        bus.src_data = {32'h0, 32'h22222222, 32'h0, 32'h11111111};
        bus.req = 4'b0101;
        cycle();
        checks++;
        if (bus.grant !== 4'b0001 || bus.hex !== 32'h11111111) begin
            failures++;
            $display("FAIL rotation_first actual=%b/%h expected=0001/11111111", bus.grant, bus.hex);
        end
        order.push_back(bus.grant_idx);
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (bus.slice_done) order.push_back(bus.grant_idx);
            checks++;
            if (dut_vec() !== m_vec()) begin
                failures++;
                $display("FAIL rotation_model c=%0d actual=%h expected=%h", c, dut_vec(), m_vec());
            end
        end
        checks++;
        if (order.size() != 4 || order[0] != 0 || order[1] != 2 || order[2] != 0 || order[3] != 2) begin
            failures++;
            $display("FAIL rotation_order actual_slices=%0d expected=4 (0,2,0,2)", order.size());
        end
    endtask

    task automatic test_single();
        int pulses;
        logic [31:0] v;
        do_reset();
        bus.req = 4'b1000;
        bus.src_data = {$urandom, $urandom, $urandom, $urandom};
        cycle();
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            v = $urandom;
            bus.src_data[127:96] = v;
            cycle();
            if (bus.slice_done) pulses++;
            checks++;
            if (bus.grant !== 4'b1000 || bus.hex !== v) begin
                failures++;
                $display("FAIL single_track c=%0d actual=%b/%h expected=1000/%h", c, bus.grant, bus.hex, v);
            end
        end
        checks++;
        if (pulses != 3) begin
            failures++;
            $display("FAIL single_pulses actual=%0d expected=3", pulses);
        end
    endtask

    task automatic test_early_release();
        logic [31:0] s0;
        do_reset();
        s0 = $urandom;
        bus.src_data = {$urandom, $urandom, $urandom, s0};
        bus.req = 4'b0011;
        cycle();
        repeat (4) cycle();
        cycle();
        checks++;
        if (bus.grant !== 4'b0010) begin
            failures++;
            $display("FAIL release_setup actual=%b expected=0010", bus.grant);
        end
        bus.req = 4'b0001;
        cycle();
        checks++;
        if (bus.grant !== 4'b0001 || bus.slice_done !== 1'b0 || bus.hex !== s0) begin
            failures++;
            $display("FAIL release_switch actual=%b/%b/%h expected=0001/0/%h",
                     bus.grant, bus.slice_done, bus.hex, s0);
        end
        bus.req = '0;
        cycle();
        checks++;
        if (bus.grant !== '0 || bus.hex !== '0 || bus.hex_valid !== 1'b0) begin
            failures++;
            $display("FAIL release_idle actual=%b/%h/%b expected=0000/0/0",
                     bus.grant, bus.hex, bus.hex_valid);
        end
    endtask

    task automatic test_freeze();
        do_reset();
        bus.src_data = {$urandom, $urandom, $urandom, $urandom};
        bus.req = 4'b0110;
        cycle();
        repeat (2) cycle();
        bus.freeze = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cycle();
            checks++;
            if (bus.grant !== 4'b0010 || bus.slice_done !== 1'b0) begin
                failures++;
                $display("FAIL freeze_hold c=%0d actual=%b/%b expected=0010/0", c, bus.grant, bus.slice_done);
            end
        end
        bus.freeze = 1'b0;
        cycle();
        checks++;
        if (bus.grant !== 4'b0010 || bus.slice_done !== 1'b0) begin
            failures++;
            $display("FAIL freeze_resume actual=%b/%b expected=0010/0", bus.grant, bus.slice_done);
        end
        cycle();
        checks++;
        if (bus.grant !== 4'b0100 || bus.slice_done !== 1'b1) begin
            failures++;
            $display("FAIL freeze_expiry actual=%b/%b expected=0100/1", bus.grant, bus.slice_done);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] s2;
        do_reset();
        s2 = $urandom;
        bus.src_data = {$urandom, s2, $urandom, $urandom};
        bus.req = 4'b0100;
        cycle();
        repeat (2) cycle();
        reset = 1'b1;
        cycle();
        checks++;
        if (dut_vec() !== '0) begin
            failures++;
            $display("FAIL reset_mid_clear actual=%h expected=0", dut_vec());
        end
        reset = 1'b0;
        cycle();
        checks++;
        if (bus.grant !== 4'b0100 || bus.hex !== s2 || bus.grant_idx !== 3'd2) begin
            failures++;
            $display("FAIL reset_mid_regrant actual=%b/%h expected=0100/%h", bus.grant, bus.hex, s2);
        end
    endtask

    task automatic test_fairness();
        int seq[$];
        int cnt[N];
        logic ok;
        do_reset();
        bus.req = 4'b1111;
        cycle();
        seq.push_back(bus.grant_idx);
        for (int c = 0; c < 63; c++) begin
            cycle();
            if (bus.slice_done) seq.push_back(bus.grant_idx);
        end
        ok = (seq.size() == 16);
        for (int i = 0; i < N; i++) cnt[i] = 0;
        foreach (seq[k]) begin
            if (seq[k] != k % N) ok = 1'b0;
            cnt[seq[k] % N]++;
        end
        for (int i = 0; i < N; i++) if (cnt[i] != 4) ok = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL fairness actual_slices=%0d counts=%0d,%0d,%0d,%0d expected=16 with 4 each in order",
                     seq.size(), cnt[0], cnt[1], cnt[2], cnt[3]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 5) == 0) bus.req = 4'($urandom_range(0, 15));
            bus.freeze = ($urandom_range(0, 3) == 0);
            bus.src_data = {$urandom, $urandom, $urandom, $urandom};
            reset = ($urandom_range(0, 99) == 0);
            cycle();
            checks++;
            if (dut_vec() !== m_vec()) begin
                failures++;
                $display("FAIL random_model c=%0d actual=%h expected=%h", c, dut_vec(), m_vec());
            end
            checks++;
            if ($countones(bus.grant) > 1 || bus.hex_valid !== (|bus.grant)) begin
                failures++;
                $display("FAIL random_invariant c=%0d grant=%b valid=%b expected one-hot and valid==|grant",
                         c, bus.grant, bus.hex_valid);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        bus.req = '0;
        bus.freeze = 1'b0;
        bus.src_data = '0;
        m_owner = -1; m_last = N - 1; m_age = 0; m_hex = '0; m_sd = 1'b0;
        test_reset();
        test_rotation();
        test_single();
        test_early_release();
        test_freeze();
        test_reset_mid();
        test_fairness();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
